// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter, valid/ready word input, framed serial output
//   clk        in   posedge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   DATA_W-bit word, sampled only on a transfer edge
//   din_valid  in   din holds a word to send
//   din_ready  out  word can be accepted this edge (idle, or last bit on sout)
//   sout       out  registered serial data, IDLE_LEVEL when not valid
//   sout_valid out  registered, sout carries a bit this cycle
//   done       out  last bit of the current word is on sout
module piso_shift_tx #(
  parameter int   DATA_W     = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              done
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              sout_q, sout_d, sout_valid_q, sout_valid_d, xfer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = xfer ? SHIFT : done ? IDLE : state_q;
  always_comb begin
    done      = state_q == SHIFT && cnt_q == '0;
    din_ready = state_q == IDLE || done;
    xfer      = din_valid && din_ready;
  end
  // the shift register holds the bits not yet on sout, aligned so the next
  // bit to send is always at the outgoing end
  always_comb begin
    sout_d       = IDLE_LEVEL;
    sout_valid_d = 1'b0;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    if (xfer) begin
      sout_d       = MSB_FIRST ? din[DATA_W-1] : din[0];
      sr_d         = MSB_FIRST ? din << 1 : din >> 1;
      cnt_d        = CW'(DATA_W - 1);
      sout_valid_d = 1'b1;
    end else if (state_q == SHIFT && !done) begin
      sout_d       = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
      sr_d         = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
      cnt_d        = cnt_q - CW'(1);
      sout_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q        <= '0;
      sr_q         <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: directed bench for piso_shift_tx (MSB-first, LSB-first and 1-bit instances)
module tb_piso_shift_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] m_din = '0, l_din = '0;
  logic       m_vld = 1'b0, l_vld = 1'b0;
  logic       m_rdy, m_sout, m_sv, m_done;
  logic       l_rdy, l_sout, l_sv, l_done;
  logic [0:0] w_din = '0;
  logic       w_vld = 1'b0;
  logic       w_rdy, w_sout, w_sv, w_done;
  int         n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  piso_shift_tx u_msb (
    .clk(clk), .rst_n(rst_n), .din(m_din), .din_valid(m_vld),
    .din_ready(m_rdy), .sout(m_sout), .sout_valid(m_sv), .done(m_done)
  );
  piso_shift_tx #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(l_din), .din_valid(l_vld),
    .din_ready(l_rdy), .sout(l_sout), .sout_valid(l_sv), .done(l_done)
  );
  piso_shift_tx #(.DATA_W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .din(w_din), .din_valid(w_vld),
    .din_ready(w_rdy), .sout(w_sout), .sout_valid(w_sv), .done(w_done)
  );
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    m_vld = 1'b1;
    m_din = 8'hFF;
    repeat (3) tick();
    n_cmp++;
    if ({m_sout, m_sv, m_done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_out got sout/sv/done=%b want 000", {m_sout, m_sv, m_done});
    end
    m_vld = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (m_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", m_rdy);
    end
    tick();
  endtask
  // drives one MSB-first word, optionally corrupting din after the transfer edge
  task automatic test_word(input logic [7:0] w, input bit corrupt, input string nm);
    m_din = w;
    m_vld = 1'b1;
    #1;
    n_cmp++;
    if (m_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready0 got %b want 1", nm, m_rdy);
    end
    tick();
    m_vld = 1'b0;
    if (corrupt) m_din = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if ({m_sout, m_sv, m_done, m_rdy} !== {w[8-i], 1'b1, i == 8, i == 8}) begin
        n_err++;
        $display("FAIL %s_bit%0d got sout/sv/done/rdy=%b want %b", nm, i,
                 {m_sout, m_sv, m_done, m_rdy}, {w[8-i], 1'b1, i == 8, i == 8});
      end
      tick();
    end
    n_cmp++;
    if ({m_sout, m_sv, m_done} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_idle got sout/sv/done=%b want 000", nm, {m_sout, m_sv, m_done});
    end
  endtask
  task automatic test_back_to_back;
    logic [15:0] s;
    s = 16'hA53C;
    m_din = 8'hA5;
    m_vld = 1'b1;
    tick();
    m_din = 8'h3C;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++;
      if ({m_sout, m_sv, m_done} !== {s[16-i], 1'b1, i == 8 || i == 16}) begin
        n_err++;
        $display("FAIL b2b_bit%0d got sout/sv/done=%b want %b", i,
                 {m_sout, m_sv, m_done}, {s[16-i], 1'b1, i == 8 || i == 16});
      end
      if (i == 8) m_vld = 1'b1;
      if (i == 9) m_vld = 1'b0;
      tick();
    end
    n_cmp++;
    if ({m_sv, m_done, m_rdy} !== 3'b001) begin
      n_err++;
      $display("FAIL b2b_idle got sv/done/rdy=%b want 001", {m_sv, m_done, m_rdy});
    end
  endtask
  task automatic test_lsb_first;
    l_din = 8'h01;
    l_vld = 1'b1;
    tick();
    l_vld = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if ({l_sout, l_sv, l_done} !== {i == 1, 1'b1, i == 8}) begin
        n_err++;
        $display("FAIL lsb_bit%0d got sout/sv/done=%b want %b", i,
                 {l_sout, l_sv, l_done}, {i == 1, 1'b1, i == 8});
      end
      tick();
    end
    n_cmp++;
    if (l_sv !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_idle got sv=%b want 0", l_sv);
    end
  endtask
  task automatic test_reset_mid_word;
    m_din = 8'hFF;
    m_vld = 1'b1;
    tick();
    m_vld = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({m_sout, m_sv} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_pre got sout/sv=%b want 11", {m_sout, m_sv});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_sout, m_sv, m_done} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_now got sout/sv/done=%b want 000", {m_sout, m_sv, m_done});
    end
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({m_sv, m_done, m_rdy} !== 3'b001) begin
      n_err++;
      $display("FAIL abort_rel got sv/done/rdy=%b want 001", {m_sv, m_done, m_rdy});
    end
    tick();
    test_word(8'h80, 1'b0, "after_abort");
  endtask
  task automatic test_width1;
    w_din = 1'b1;
    w_vld = 1'b1;
    tick();
    w_din = 1'b0;
    n_cmp++;
    if ({w_sout, w_sv, w_done, w_rdy} !== 4'b1111) begin
      n_err++;
      $display("FAIL w1_bit0 got sout/sv/done/rdy=%b want 1111", {w_sout, w_sv, w_done, w_rdy});
    end
    tick();
    w_vld = 1'b0;
    n_cmp++;
    if ({w_sout, w_sv, w_done} !== 3'b011) begin
      n_err++;
      $display("FAIL w1_bit1 got sout/sv/done=%b want 011", {w_sout, w_sv, w_done});
    end
    tick();
    n_cmp++;
    if ({w_sv, w_done} !== 2'b00) begin
      n_err++;
      $display("FAIL w1_idle got sv/done=%b want 00", {w_sv, w_done});
    end
  endtask
  initial begin
    test_reset();
    test_word(8'hA5, 1'b0, "a5");
    tick();
    test_back_to_back();
    tick();
    test_lsb_first();
    tick();
    test_word(8'hA5, 1'b1, "din_hold");
    tick();
    test_reset_mid_word();
    tick();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
